truth_table_capture: RTL and testbench

- Characterizer for N_IN-input combinational logic blocks (gate-level truth-table modules).
- Sweeps every input combination into a device under test, waits a settle interval, samples the single output, and assembles the hex truth-table code, e.g. 8'hC0 for a 3-input block.
- Inverse of the truth-table modules: those map a code to logic; this block recovers the code from the logic.
- Used in self-check benches and on-chip verification of synthesized circuits.

---
 rtl/truth_table_capture_if.sv | 41 ++++
 rtl/truth_table_capture.sv | 165 ++++++++++++++++
 tb/tb_truth_table_capture.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_capture_if.sv
// Signal bundle between a sweep host and truth_table_capture.
// Expected-code check signals exist only when TRUTH_TABLE_CAPTURE_EXPECT_EN is defined.
interface truth_table_capture_if #(
   parameter int unsigned N_IN = 3
) ();
   localparam int unsigned W = 1 << N_IN;

   logic            start;
   logic            busy;
   logic            done;
   logic [N_IN-1:0] dut_in;
   logic            dut_out;
   logic [W-1:0]    code;
   logic            valid;

`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
   logic [W-1:0]    expected_code;
   logic            mismatch;
   logic [N_IN-1:0] first_bad_row;

   modport master (
      output start, dut_out, expected_code,
      input  busy, done, dut_in, code, valid, mismatch, first_bad_row
   );

   modport slave (
      input  start, dut_out, expected_code,
      output busy, done, dut_in, code, valid, mismatch, first_bad_row
   );
`else
   modport master (
      output start, dut_out,
      input  busy, done, dut_in, code, valid
   );

   modport slave (
      input  start, dut_out,
      output busy, done, dut_in, code, valid
   );
`endif
endinterface

// File: rtl/truth_table_capture.sv
// Sweeps all 2**N_IN input rows into a combinational block and assembles its truth-table code.
// Define TRUTH_TABLE_CAPTURE_EXPECT_EN to add expected-code comparison (mismatch, first_bad_row).
module truth_table_capture #(
   parameter int unsigned N_IN          = 3,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input logic                  clk,
   input logic                  rst,
   truth_table_capture_if.slave bus
);
   localparam int unsigned W  = 1 << N_IN;
   localparam int unsigned RW = N_IN + 1;
   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_e;

   state_e          state_q,  state_d;
   logic [RW-1:0]   row_q,    row_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic            busy_q,   busy_d;
   logic            done_q,   done_d;
   logic [N_IN-1:0] dut_in_q, dut_in_d;
   logic [W-1:0]    code_q,   code_d;
   logic            valid_q,  valid_d;

   logic [N_IN-1:0] bit_idx;
   logic            last_row;
   logic            settle_last;

`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
   logic [W-1:0]    expected_q,      expected_d;
   logic            mismatch_q,      mismatch_d;
   logic [N_IN-1:0] first_bad_row_q, first_bad_row_d;
   logic            bad_seen_q,      bad_seen_d;
`endif

   // Row k lands in code[W-1-k]; for k < W that is the bitwise complement of k.
   assign bit_idx     = ~row_q[N_IN-1:0];
   assign last_row    = (row_q == RW'(W - 1));
   assign settle_last = (settle_q == SW'(SETTLE_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      settle_d = settle_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dut_in_d = dut_in_q;
      code_d   = code_q;
      valid_d  = valid_q;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
      expected_d      = expected_q;
      mismatch_d      = mismatch_q;
      first_bad_row_d = first_bad_row_q;
      bad_seen_d      = bad_seen_q;
`endif

      case (state_q)
         S_IDLE: begin
            dut_in_d = '0;
            if (bus.start) begin
               state_d  = S_APPLY;
               row_d    = '0;
               settle_d = '0;
               code_d   = '0;
               valid_d  = 1'b0;
               busy_d   = 1'b1;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
               expected_d      = bus.expected_code;
               mismatch_d      = 1'b0;
               first_bad_row_d = '0;
               bad_seen_d      = 1'b0;
`endif
            end
         end

         S_APPLY: begin
            if (settle_last) begin
               state_d  = S_SAMPLE;
               settle_d = '0;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end

         S_SAMPLE: begin
            code_d[bit_idx] = bus.dut_out;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
            // Rows are visited in ascending order, so the first miss is the lowest row.
            if (!bad_seen_q && (bus.dut_out != expected_q[bit_idx])) begin
               bad_seen_d      = 1'b1;
               first_bad_row_d = row_q[N_IN-1:0];
            end
`endif
            if (last_row) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               dut_in_d = '0;
            end else begin
               state_d  = S_APPLY;
               row_d    = row_q + RW'(1);
               dut_in_d = row_q[N_IN-1:0] + N_IN'(1);
            end
         end

         S_DONE: begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            valid_d  = 1'b1;
            dut_in_d = '0;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
            mismatch_d = (code_q != expected_q);
`endif
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dut_in_q <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
         expected_q      <= '0;
         mismatch_q      <= 1'b0;
         first_bad_row_q <= '0;
         bad_seen_q      <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dut_in_q <= dut_in_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
         expected_q      <= expected_d;
         mismatch_q      <= mismatch_d;
         first_bad_row_q <= first_bad_row_d;
         bad_seen_q      <= bad_seen_d;
`endif
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.dut_in = dut_in_q;
   assign bus.code   = code_q;
   assign bus.valid  = valid_q;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
   assign bus.mismatch      = mismatch_q;
   assign bus.first_bad_row = first_bad_row_q;
`endif
endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture at (N_IN=3, SETTLE=4) and (N_IN=2, SETTLE=1), checked every cycle
// against a timeline model; covers TRUTH_TABLE_CAPTURE_EXPECT_EN when that macro is defined.
module tb_truth_table_capture;
   localparam int N0 = 3;
   localparam int S0 = 4;
   localparam int W0 = 8;
   localparam int N1 = 2;
   localparam int S1 = 1;
   localparam int W1 = 4;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   fails    = 0;
   int   donecnt0 = 0;
   int   sel0, sel1;
   logic [63:0] tt0, tt1;

   // Model: mj = cycles since start accept (-1 when idle), mcode = bits captured so far.
   int          mj    [2] = '{-1, -1};
   logic [63:0] mcode [2] = '{64'd0, 64'd0};
   logic        mvalid[2] = '{1'b0, 1'b0};
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
   logic [63:0] mexp  [2] = '{64'd0, 64'd0};
   logic        mmis  [2] = '{1'b0, 1'b0};
   int          mfbr  [2] = '{0, 0};
`endif

   truth_table_capture_if #(.N_IN(N0)) if0 ();
   truth_table_capture_if #(.N_IN(N1)) if1 ();

   truth_table_capture #(.N_IN(N0), .SETTLE_CYCLES(S0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   truth_table_capture #(.N_IN(N1), .SETTLE_CYCLES(S1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Logic blocks under characterisation; in1 is the MSB of the row.
   function automatic logic fval(input int sel, input int n, input int row, input logic [63:0] tt);
      logic [5:0] x;
      x = 6'(row);
      case (sel)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return ^x;
         3:       return ~x[2] & ~x[1];
         4:       return row == ((1 << n) - 1);
         5:       return (~x[2] & ~x[1]) | (x[2] & ~x[1] & x[0]);
         default: return tt[x];
      endcase
   endfunction

   always_comb if0.dut_out = fval(sel0, N0, 32'(if0.dut_in), tt0);
   always_comb if1.dut_out = fval(sel1, N1, 32'(if1.dut_in), tt1);

   function automatic int wof(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   function automatic int pof(input int i);
      return (i == 0) ? S0 + 1 : S1 + 1;
   endfunction

   function automatic logic e_busy(input int i);
      return mj[i] >= 0;
   endfunction

   function automatic logic e_done(input int i);
      return mj[i] == wof(i) * pof(i);
   endfunction

   function automatic logic [63:0] e_din(input int i);
      if (mj[i] >= 0 && mj[i] < wof(i) * pof(i)) return 64'(mj[i] / pof(i));
      return 64'd0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input int i);
      int         w, per, r;
      logic [5:0] bi;
      logic       st;
      w   = wof(i);
      per = pof(i);
      st  = (i == 0) ? if0.start : if1.start;
      if (mj[i] < 0) begin
         if (st) begin
            mj[i]     = 0;
            mcode[i]  = '0;
            mvalid[i] = 1'b0;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
            mexp[i] = (i == 0) ? 64'(if0.expected_code) : 64'(if1.expected_code);
            mmis[i] = 1'b0;
`endif
         end
      end else if (mj[i] == w * per) begin
         mvalid[i] = 1'b1;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
         mmis[i] = (mcode[i] != mexp[i]);
         mfbr[i] = 0;
         for (int k = w - 1; k >= 0; k--) begin
            bi = 6'(w - 1 - k);
            if (mcode[i][bi] != mexp[i][bi]) mfbr[i] = k;
         end
`endif
         mj[i] = -1;
      end else begin
         if (mj[i] % per == per - 1) begin
            r  = mj[i] / per;
            bi = 6'(w - 1 - r);
            mcode[i][bi] = (i == 0) ? fval(sel0, N0, r, tt0) : fval(sel1, N1, r, tt1);
         end
         mj[i] = mj[i] + 1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mj[i]     = -1;
            mcode[i]  = '0;
            mvalid[i] = 1'b0;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
            mexp[i] = '0;
            mmis[i] = 1'b0;
            mfbr[i] = 0;
`endif
         end
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy0",   64'(if0.busy),   64'(e_busy(0)));
         chk("done0",   64'(if0.done),   64'(e_done(0)));
         chk("dut_in0", 64'(if0.dut_in), e_din(0));
         chk("code0",   64'(if0.code),   mcode[0]);
         chk("valid0",  64'(if0.valid),  64'(mvalid[0]));
         chk("busy1",   64'(if1.busy),   64'(e_busy(1)));
         chk("done1",   64'(if1.done),   64'(e_done(1)));
         chk("dut_in1", 64'(if1.dut_in), e_din(1));
         chk("code1",   64'(if1.code),   mcode[1]);
         chk("valid1",  64'(if1.valid),  64'(mvalid[1]));
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
         chk("mismatch0", 64'(if0.mismatch), 64'(mmis[0]));
         chk("mismatch1", 64'(if1.mismatch), 64'(mmis[1]));
         if (mj[0] < 0) chk("first_bad_row0", 64'(if0.first_bad_row), 64'(mfbr[0]));
         if (mj[1] < 0) chk("first_bad_row1", 64'(if1.first_bad_row), 64'(mfbr[1]));
`endif
      end
   end

   always @(negedge clk) if (!rst && if0.done) donecnt0 <= donecnt0 + 1;

   task automatic set_start(input int i, input logic v);
      if (i == 0) if0.start = v;
      else        if1.start = v;
   endtask

   task automatic pulse(input int i);
      @(posedge clk); #1; set_start(i, 1'b1);
      @(posedge clk); #1; set_start(i, 1'b0);
   endtask

   task automatic wait_done(input int i, input int maxc, output int n);
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < maxc) begin
         @(posedge clk); #1;
         n++;
         hit = (i == 0) ? if0.done : if1.done;
      end
      if (!hit) begin
         checks++; fails++;
         $display("FAIL wait_done%0d actual=no_done required=done_within_%0d", i, maxc);
      end
   endtask

   task automatic wait_row(input int i, input int row, input int maxc);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < maxc) begin
         @(posedge clk); #1;
         n++;
         hit = (i == 0) ? (32'(if0.dut_in) == row && if0.busy) : (32'(if1.dut_in) == row && if1.busy);
      end
      if (!hit) begin
         checks++; fails++;
         $display("FAIL wait_row%0d actual=not_reached required=row_%0d", i, row);
      end
   endtask

   task automatic sweep(input int i, input int sel, output int n);
      if (i == 0) sel0 = sel;
      else        sel1 = sel;
      pulse(i);
      wait_done(i, 200, n);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, c0;
      rst = 1'b1;
      if0.start = 1'b0;
      if1.start = 1'b0;
      sel0 = 0; sel1 = 0; tt0 = '0; tt1 = '0;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
      if0.expected_code = '0;
      if1.expected_code = '0;
`endif
      #12;
      chk("rst_busy",   64'(if0.busy),   64'd0);
      chk("rst_done",   64'(if0.done),   64'd0);
      chk("rst_dut_in", 64'(if0.dut_in), 64'd0);
      chk("rst_code",   64'(if0.code),   64'd0);
      chk("rst_valid",  64'(if0.valid),  64'd0);
      @(negedge clk); rst = 1'b0;

      sweep(0, 3, n);
      chk("lat_c0", 64'(n), 64'd40);
      chk("code_c0_at_done", 64'(if0.code), 64'hC0);
      @(posedge clk); #1;
      chk("code_c0",  64'(if0.code),  64'hC0);
      chk("valid_c0", 64'(if0.valid), 64'd1);
      chk("model_c0", mcode[0],       64'hC0);

      sweep(0, 1, n); @(posedge clk); #1;
      chk("code_one", 64'(if0.code), 64'hFF);
      sweep(0, 0, n); @(posedge clk); #1;
      chk("code_zero",  64'(if0.code),  64'h00);
      chk("valid_zero", 64'(if0.valid), 64'd1);
      sweep(0, 2, n); @(posedge clk); #1;
      chk("code_xor",  64'(if0.code), 64'h69);
      chk("model_xor", mcode[0],      64'h69);

      sweep(1, 4, n);
      chk("lat_and2", 64'(n), 64'd8);
      @(posedge clk); #1;
      chk("code_and2", 64'(if1.code), 64'h1);

      // Asynchronous reset in the middle of row 4.
      sel0 = 3;
      pulse(0);
      wait_row(0, 4, 100);
      #2; rst = 1'b1; #1;
      chk("midrst_busy",   64'(if0.busy),   64'd0);
      chk("midrst_dut_in", 64'(if0.dut_in), 64'd0);
      chk("midrst_code",   64'(if0.code),   64'd0);
      chk("midrst_valid",  64'(if0.valid),  64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      sweep(0, 2, n);
      chk("lat_after_rst", 64'(n), 64'd40);
      @(posedge clk); #1;
      chk("code_after_rst", 64'(if0.code), 64'h69);

      // Starts at rows 2 and 6 and during DONE are ignored.
      c0 = donecnt0;
      sel0 = 5;
      pulse(0);
      wait_row(0, 2, 100);
      set_start(0, 1'b1); @(posedge clk); #1; set_start(0, 1'b0);
      wait_row(0, 6, 100);
      set_start(0, 1'b1); @(posedge clk); #1; set_start(0, 1'b0);
      wait_done(0, 100, n);
      set_start(0, 1'b1); @(posedge clk); #1; set_start(0, 1'b0);
      chk("busy_after_done_start", 64'(if0.busy), 64'd0);
      chk("code_c4", 64'(if0.code), 64'hC4);
      repeat (10) @(posedge clk); #1;
      chk("busy_idle", 64'(if0.busy), 64'd0);
      chk("done_pulses", 64'(donecnt0 - c0), 64'd1);

`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
      if0.expected_code = 8'hC0;
      sweep(0, 5, n); @(posedge clk); #1;
      chk("exp_mismatch_c4", 64'(if0.mismatch),      64'd1);
      chk("exp_fbr_c4",      64'(if0.first_bad_row), 64'd5);
      sweep(0, 3, n); @(posedge clk); #1;
      chk("exp_mismatch_c0", 64'(if0.mismatch), 64'd0);
`endif

      // Random start traffic and random logic functions on both instances.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if0.start = ($urandom_range(0, 5) == 0);
         if1.start = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 30) == 0) begin
            sel0 = int'($urandom_range(0, 6));
            tt0  = {$urandom, $urandom};
         end
         if ($urandom_range(0, 30) == 0) begin
            sel1 = int'($urandom_range(0, 6));
            tt1  = {$urandom, $urandom};
         end
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
         if ($urandom_range(0, 20) == 0) if0.expected_code = 8'($urandom);
         if ($urandom_range(0, 20) == 0) if1.expected_code = 4'($urandom);
`endif
      end
      if0.start = 1'b0;
      if1.start = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk("final_idle0", 64'(if0.busy), 64'd0);
      chk("final_idle1", 64'(if1.busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
